vga_fifo_rdctrl: RTL and testbench

Read-side controller for the VGA line FIFO. It sits in the pixel-clock domain between the FIFO pointer/flag logic and the pixel generator. It issues FIFO read requests, captures words from the dual-ported line memory, and unpacks each 32-bit word into 8-, 16- or 32-bit pixels on demand. It keeps a small prefetch buffer so that 32bpp runs at one pixel per clock, and it flags underruns when a pixel is requested and none is available.

---
 rtl/vga_fifo_rdctrl_if.sv | 23 ++
 rtl/vga_fifo_rdctrl.sv | 146 ++++++++++++++
 tb/tb_vga_fifo_rdctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_fifo_rdctrl_if.sv
// Signal bundle between the VGA line-FIFO read controller and its surroundings:
// FIFO flag/request/data, pixel request/response and control.
interface vga_fifo_rdctrl_if;
    logic        en_i;
    logic [1:0]  cdepth_i;
    logic        rd_empty_i;
    logic        rreq_o;
    logic [31:0] rdat_i;
    logic        pix_req_i;
    logic [31:0] pix_o;
    logic        pix_vld_o;
    logic        underrun_o;

    modport master (
        input  en_i, cdepth_i, rd_empty_i, rdat_i, pix_req_i,
        output rreq_o, pix_o, pix_vld_o, underrun_o
    );

    modport slave (
        output en_i, cdepth_i, rd_empty_i, rdat_i, pix_req_i,
        input  rreq_o, pix_o, pix_vld_o, underrun_o
    );
endinterface

// File: rtl/vga_fifo_rdctrl.sv
// Read-side controller for the VGA line FIFO: fetches 32-bit words with a one-word
// prefetch and unpacks them MSB-first into 8/16/32-bit pixels, flagging underruns.
module vga_fifo_rdctrl (
    input  logic              clk_i,
    input  logic              rst_i,
    vga_fifo_rdctrl_if.master bus
);
    logic [31:0] wreg_reg, wreg_next;
    logic [31:0] pbuf_reg, pbuf_next;
    logic [31:0] pix_reg, pix_next;
    logic        wvalid_reg, wvalid_next;
    logic        pvalid_reg, pvalid_next;
    logic        inflight_reg, inflight_next;
    logic        pix_vld_reg, pix_vld_next;
    logic        underrun_reg, underrun_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [1:0]  depth_reg, depth_next;
    logic        en_d_reg;

    logic [1:0]  last_idx;
    logic [1:0]  occ;
    logic        rel;
    logic        free;
    logic        rreq;
    logic [31:0] pix_sel;
    logic [7:0]  byte_lane [0:3];

    // Lane 0 is the most significant byte, matching the pixel output order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = wreg_reg[31-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        last_idx = 2'd0;
        pix_sel  = wreg_reg;
        case (depth_reg)
            2'b00: begin
                last_idx = 2'd3;
                pix_sel  = {24'h0, byte_lane[cnt_reg]};
            end
            2'b01: begin
                last_idx = 2'd1;
                pix_sel  = cnt_reg[0] ? {16'h0, wreg_reg[15:0]} : {16'h0, wreg_reg[31:16]};
            end
            default: begin
                last_idx = 2'd0;
                pix_sel  = wreg_reg;
            end
        endcase
    end

    assign occ  = {1'b0, wvalid_reg} + {1'b0, pvalid_reg} + {1'b0, inflight_reg};
    assign rel  = bus.en_i & bus.pix_req_i & wvalid_reg & (cnt_reg == last_idx);
    assign free = ~wvalid_reg | rel;
    assign rreq = bus.en_i & ~bus.rd_empty_i & ~rst_i & ((occ < 2'd2) | rel);

    always_comb begin
        wreg_next     = wreg_reg;
        pbuf_next     = pbuf_reg;
        pix_next      = pix_reg;
        wvalid_next   = wvalid_reg;
        pvalid_next   = pvalid_reg;
        inflight_next = rreq;
        pix_vld_next  = bus.pix_req_i;
        underrun_next = underrun_reg;
        cnt_next      = cnt_reg;
        depth_next    = (bus.en_i & ~en_d_reg) ? bus.cdepth_i : depth_reg;

        if (!bus.en_i) begin
            // Disabled: drop everything, in-flight data is simply not captured.
            wvalid_next   = 1'b0;
            pvalid_next   = 1'b0;
            cnt_next      = 2'd0;
            underrun_next = 1'b0;
            if (bus.pix_req_i) begin
                pix_next = 32'h0;
            end
        end else begin
            // The prefetched word is older than arriving data, so it has priority for wreg.
            if (free) begin
                if (pvalid_reg) begin
                    wreg_next   = pbuf_reg;
                    wvalid_next = 1'b1;
                    pvalid_next = 1'b0;
                    if (inflight_reg) begin
                        pbuf_next   = bus.rdat_i;
                        pvalid_next = 1'b1;
                    end
                end else if (inflight_reg) begin
                    wreg_next   = bus.rdat_i;
                    wvalid_next = 1'b1;
                end else begin
                    wvalid_next = 1'b0;
                end
            end else if (inflight_reg) begin
                pbuf_next   = bus.rdat_i;
                pvalid_next = 1'b1;
            end

            if (bus.pix_req_i) begin
                if (wvalid_reg) begin
                    pix_next = pix_sel;
                    cnt_next = rel ? 2'd0 : cnt_reg + 2'd1;
                end else begin
                    pix_next      = 32'h0;
                    underrun_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wreg_reg     <= 32'h0;
            pbuf_reg     <= 32'h0;
            pix_reg      <= 32'h0;
            wvalid_reg   <= 1'b0;
            pvalid_reg   <= 1'b0;
            inflight_reg <= 1'b0;
            pix_vld_reg  <= 1'b0;
            underrun_reg <= 1'b0;
            cnt_reg      <= 2'd0;
            depth_reg    <= 2'b10;
            en_d_reg     <= 1'b0;
        end else begin
            wreg_reg     <= wreg_next;
            pbuf_reg     <= pbuf_next;
            pix_reg      <= pix_next;
            wvalid_reg   <= wvalid_next;
            pvalid_reg   <= pvalid_next;
            inflight_reg <= inflight_next;
            pix_vld_reg  <= pix_vld_next;
            underrun_reg <= underrun_next;
            cnt_reg      <= cnt_next;
            depth_reg    <= depth_next;
            en_d_reg     <= bus.en_i;
        end
    end

    assign bus.rreq_o     = rreq;
    assign bus.pix_o      = pix_reg;
    assign bus.pix_vld_o  = pix_vld_reg;
    assign bus.underrun_o = underrun_reg;
endmodule

// File: tb/tb_vga_fifo_rdctrl.sv
// Scoreboard bench for vga_fifo_rdctrl: a FIFO model feeds words, stimulus queues the
// expected pixels, and a monitor pops and compares every valid pixel.
module tb_vga_fifo_rdctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_fifo_rdctrl_if bus ();

    vga_fifo_rdctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    // FIFO model: word requested in cycle N is on rdat in cycle N+1.
    logic [31:0] fmem [0:255];
    int fcount = 0;
    int fptr   = 0;
    assign bus.rd_empty_i = (fptr >= fcount);
    always @(posedge clk) begin
        if (bus.rreq_o) begin
            bus.rdat_i <= fmem[fptr];
            fptr       <= fptr + 1;
        end
    end

    typedef struct {
        logic [31:0] pix;
        logic        und;
    } exp_t;
    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int rc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        fmem[fcount] = w;
        fcount++;
    endtask

    task automatic req(input logic [31:0] p, input logic u);
        exp_t e;
        e.pix = p;
        e.und = u;
        bus.pix_req_i = 1'b1;
        exp_q.push_back(e);
        cyc();
    endtask

    // Disable for two cycles, then enable with a new depth; returns at the start of cycle 2.
    task automatic restart(input logic [1:0] d, output int r0);
        bus.pix_req_i = 1'b0;
        bus.en_i = 1'b0;
        cyc();
        cyc();
        bus.cdepth_i = d;
        bus.en_i = 1'b1;
        r0 = rc;
        cyc();
        cyc();
    endtask

    initial begin
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (bus.rreq_o === 1'b1) rc++;
                    if (bus.pix_vld_o === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL pix_unexpected actual=%h required=none", bus.pix_o);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("pix", bus.pix_o, e.pix);
                            chk("underrun_with_pix", {31'h0, bus.underrun_o}, {31'h0, e.und});
                        end
                    end
                end
            end
            begin : stim
                int r0;
                rst = 1'b1;
                bus.en_i = 1'b1;
                bus.cdepth_i = 2'b10;
                bus.pix_req_i = 1'b0;
                push_word(32'hDEADBEEF);

                // Reset held 3 cycles with enable and a non-empty FIFO.
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("rst_rreq", {31'h0, bus.rreq_o}, 32'h0);
                    cyc();
                end
                rst = 1'b0;
                @(negedge clk);
                chk("post_rst_rreq", {31'h0, bus.rreq_o}, 32'h1);
                chk("post_rst_pix", bus.pix_o, 32'h0);
                chk("post_rst_vld", {31'h0, bus.pix_vld_o}, 32'h0);
                chk("post_rst_und", {31'h0, bus.underrun_o}, 32'h0);
                cyc();
                cyc();

                // 8bpp unpack.
                bus.en_i = 1'b0;
                cyc();
                push_word(32'h11223344);
                push_word(32'h55667788);
                restart(2'b00, r0);
                req(32'h11, 1'b0); req(32'h22, 1'b0); req(32'h33, 1'b0); req(32'h44, 1'b0);
                chk("bpp8_rreq_before_p5", rc - r0, 2);
                req(32'h55, 1'b0); req(32'h66, 1'b0); req(32'h77, 1'b0); req(32'h88, 1'b0);
                bus.pix_req_i = 1'b0;
                cyc();
                cyc();
                chk("bpp8_rreq_total", rc - r0, 2);

                // 16bpp with wrap into the next word without a gap.
                bus.en_i = 1'b0;
                cyc();
                push_word(32'hAAAA5555);
                push_word(32'h12345678);
                restart(2'b01, r0);
                req(32'hAAAA, 1'b0); req(32'h5555, 1'b0); req(32'h1234, 1'b0); req(32'h5678, 1'b0);
                bus.pix_req_i = 1'b0;
                cyc();
                cyc();

                // 32bpp throughput over 64 words.
                bus.en_i = 1'b0;
                cyc();
                for (int i = 0; i < 64; i++) push_word((32'(i) * 32'h01010101) ^ 32'h5A5A0000);
                restart(2'b10, r0);
                for (int i = 0; i < 64; i++) begin
                    req((32'(i) * 32'h01010101) ^ 32'h5A5A0000, 1'b0);
                    if (i == 31) chk("bpp32_rreq_per_cycle", rc - r0, 34);
                end
                bus.pix_req_i = 1'b0;
                cyc();
                cyc();
                @(negedge clk);
                chk("bpp32_rreq_total", rc - r0, 64);
                chk("bpp32_no_underrun", {31'h0, bus.underrun_o}, 32'h0);
                cyc();

                // Underrun with a single word at 32bpp.
                bus.en_i = 1'b0;
                cyc();
                push_word(32'hCAFEF00D);
                restart(2'b11, r0);
                req(32'hCAFEF00D, 1'b0); req(32'h0, 1'b1); req(32'h0, 1'b1);
                bus.pix_req_i = 1'b0;
                cyc();
                cyc();
                @(negedge clk);
                chk("underrun_sticky", {31'h0, bus.underrun_o}, 32'h1);
                cyc();
                bus.en_i = 1'b0;
                @(negedge clk);
                chk("underrun_until_disable", {31'h0, bus.underrun_o}, 32'h1);
                cyc();
                @(negedge clk);
                chk("underrun_cleared", {31'h0, bus.underrun_o}, 32'h0);
                cyc();
                // Requests while disabled give zero pixels without underrun.
                req(32'h0, 1'b0);
                bus.pix_req_i = 1'b0;
                cyc();

                // Flush mid-word at 8bpp, re-enable at 16bpp.
                push_word(32'h01020304);
                push_word(32'hA1B2C3D4);
                push_word(32'h55667788);
                restart(2'b00, r0);
                req(32'h01, 1'b0); req(32'h02, 1'b0);
                restart(2'b01, r0);
                req(32'h5566, 1'b0); req(32'h7788, 1'b0);
                req(32'h0, 1'b1);
                bus.pix_req_i = 1'b0;
                cyc();
                cyc();
                chk("flush_rreq_total", rc - r0, 1);
                chk("queue_drained", exp_q.size(), 0);
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
